// File: rtl/pcm_channel_scheduler_if.sv
// DSP-side sample port: valid/ready handshake carrying a channel tag and sample.
interface pcm_channel_scheduler_if #(
  parameter int DATA_W = 24
) ();
  logic              dsp_valid;
  logic              dsp_ready;
  logic              dsp_chan;
  logic [DATA_W-1:0] dsp_data;

  modport master (
    output dsp_valid,
    output dsp_chan,
    output dsp_data,
    input  dsp_ready
  );

  modport slave (
    input  dsp_valid,
    input  dsp_chan,
    input  dsp_data,
    output dsp_ready
  );
endinterface

// File: rtl/pcm_channel_scheduler.sv
// Captures left/right PCM samples into one-deep slots and serialises them
// onto the shared DSP port; tracks left-frame period for lock detection.
module pcm_channel_scheduler #(
  parameter int DATA_W        = 24,
  parameter int PERIOD_W      = 16,
  parameter int MIN_PERIOD    = 2000,
  parameter int MAX_PERIOD    = 2600,
  parameter int LOCK_COUNT    = 4,
  parameter int GATE_UNLOCKED = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                l_dout_valid,
  input  logic                r_dout_valid,
  input  logic [DATA_W-1:0]   l_pcm_data,
  input  logic [DATA_W-1:0]   r_pcm_data,
  pcm_channel_scheduler_if.master dsp,
  input  logic                clr_status,
  output logic                overrun_l,
  output logic                overrun_r,
  output logic                locked,
  output logic [PERIOD_W-1:0] frame_period
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEND_L = 2'd1;
  localparam logic [1:0] SEND_R = 2'd2;

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [GW-1:0] LOCK_C = GW'(LOCK_COUNT);
  localparam logic [PERIOD_W-1:0] PER_SAT = '1;
  localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] MAX_P = PERIOD_W'(MAX_PERIOD);
  localparam logic [PERIOD_W-1:0] TO_P  = PERIOD_W'(MAX_PERIOD + 1);

  logic [1:0] rsync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rsync_q <= '0;
    else          rsync_q <= {rsync_q[0], 1'b1};
  end

  assign rst_n = rsync_q[1];

  logic [1:0]          l_vs_q, r_vs_q;
  logic                l_pend_q, l_pend_d;
  logic                r_pend_q, r_pend_d;
  logic [DATA_W-1:0]   l_slot_q, l_slot_d;
  logic [DATA_W-1:0]   r_slot_q, r_slot_d;
  logic [1:0]          state_q, state_d;
  logic                valid_q, valid_d;
  logic                chan_q, chan_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                ovr_l_q, ovr_l_d;
  logic                ovr_r_q, ovr_r_d;
  logic [PERIOD_W-1:0] per_q, per_d;
  logic [PERIOD_W-1:0] fper_q, fper_d;
  logic [GW-1:0]       good_q, good_d;
  logic                lock_q, lock_d;

  logic l_ev, r_ev, l_cap, r_cap, gate, hs;
  logic l_drain, r_drain, l_load, r_load;

  always_comb begin
    l_ev = l_vs_q[0] & ~l_vs_q[1];
    r_ev = r_vs_q[0] & ~r_vs_q[1];

    per_d  = (per_q == PER_SAT) ? per_q : per_q + 1'b1;
    fper_d = fper_q;
    good_d = good_q;
    lock_d = lock_q;
    if (l_ev) begin
      per_d  = {{(PERIOD_W-1){1'b0}}, 1'b1};
      fper_d = per_q;
      if (per_q >= MIN_P && per_q <= MAX_P) begin
        good_d = (good_q == LOCK_C) ? good_q : good_q + 1'b1;
        lock_d = (good_d == LOCK_C);
      end else begin
        good_d = '0;
        lock_d = 1'b0;
      end
    end else if (per_q == TO_P) begin
      good_d = '0;
      lock_d = 1'b0;
    end

    // gating follows the lock state including this edge's measurement
    gate  = (GATE_UNLOCKED != 0) && !lock_d;
    l_cap = l_ev & ~gate;
    r_cap = r_ev & ~gate;

    hs      = valid_q & dsp.dsp_ready;
    l_drain = hs & (state_q == SEND_L);
    r_drain = hs & (state_q == SEND_R);

    state_d = state_q;
    valid_d = valid_q;
    chan_d  = chan_q;
    data_d  = data_q;
    l_load  = 1'b0;
    r_load  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (l_pend_q)      l_load = 1'b1;
        else if (r_pend_q) r_load = 1'b1;
      end
      SEND_L: begin
        if (hs) begin
          if (r_pend_q) r_load = 1'b1;
          else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
      end
      SEND_R: begin
        if (hs) begin
          if (l_pend_q) l_load = 1'b1;
          else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    if (l_load) begin
      state_d = SEND_L;
      valid_d = 1'b1;
      chan_d  = 1'b0;
      data_d  = l_slot_q;
    end
    if (r_load) begin
      state_d = SEND_R;
      valid_d = 1'b1;
      chan_d  = 1'b1;
      data_d  = r_slot_q;
    end

    // pending means unsent data waits in the slot; the in-flight copy is in data_q
    l_slot_d = l_cap ? l_pcm_data : l_slot_q;
    r_slot_d = r_cap ? r_pcm_data : r_slot_q;
    l_pend_d = l_cap | (l_pend_q & ~l_load);
    r_pend_d = r_cap | (r_pend_q & ~r_load);

    ovr_l_d = (l_cap & (l_pend_q | (state_q == SEND_L)) & ~l_drain)
            | (ovr_l_q & ~clr_status);
    ovr_r_d = (r_cap & (r_pend_q | (state_q == SEND_R)) & ~r_drain)
            | (ovr_r_q & ~clr_status);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_vs_q   <= '0;
      r_vs_q   <= '0;
      l_pend_q <= 1'b0;
      r_pend_q <= 1'b0;
      l_slot_q <= '0;
      r_slot_q <= '0;
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      chan_q   <= 1'b0;
      data_q   <= '0;
      ovr_l_q  <= 1'b0;
      ovr_r_q  <= 1'b0;
      per_q    <= '0;
      fper_q   <= '0;
      good_q   <= '0;
      lock_q   <= 1'b0;
    end else begin
      l_vs_q   <= {l_vs_q[0], l_dout_valid};
      r_vs_q   <= {r_vs_q[0], r_dout_valid};
      l_pend_q <= l_pend_d;
      r_pend_q <= r_pend_d;
      l_slot_q <= l_slot_d;
      r_slot_q <= r_slot_d;
      state_q  <= state_d;
      valid_q  <= valid_d;
      chan_q   <= chan_d;
      data_q   <= data_d;
      ovr_l_q  <= ovr_l_d;
      ovr_r_q  <= ovr_r_d;
      per_q    <= per_d;
      fper_q   <= fper_d;
      good_q   <= good_d;
      lock_q   <= lock_d;
    end
  end

  assign dsp.dsp_valid = valid_q;
  assign dsp.dsp_chan  = chan_q;
  assign dsp.dsp_data  = data_q;
  assign overrun_l     = ovr_l_q;
  assign overrun_r     = ovr_r_q;
  assign locked        = lock_q;
  assign frame_period  = fper_q;

endmodule
